// File: rtl/hyst_pkg.sv
// Class encodings and sizing helper shared by the hysteresis threshold stage.
package hyst_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } hyst_class_e;

    function automatic int unsigned col_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hyst_line_buffer.sv
// One-bit-per-column line memory holding the previous row's final edge bits.
// Registered read; a same-cycle write to the read column returns the old bit.
module hyst_line_buffer #(
    parameter int unsigned Depth = 640,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic             wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic             rdata_o
);

    logic mem_q [Depth];
    logic rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hysteresis_threshold.sv
// Streaming dual-threshold edge classifier with causal weak-pixel promotion.
// Define HYST_STATS_EN to enable the per-frame edge counter on edge_count.
module hysteresis_threshold
    import hyst_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned CNT_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic [DATA_W-1:0] In1,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic [DATA_W-1:0] thr_low,
    input  logic [DATA_W-1:0] thr_high,
    output logic              u,
    output logic [1:0]        out_class,
    output logic              out_valid,
    output logic              line_err,
    output logic [CNT_W-1:0]  edge_count
);

    localparam int unsigned      COL_W    = col_width(IMG_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    logic              accept;
    logic [DATA_W-1:0] low_q, high_q, cur_low, cur_high, eff_low;
    logic [COL_W-1:0]  col_q, col_d, pix_col, s1_col_q;
    logic              first_row_q, first_row_d, pix_first;
    logic              line_err_q, line_err_d;
    hyst_class_e       pix_class, s1_class_q;
    logic              s1_valid_q, s1_first_q;
    logic              above_raw, above, above_left, left, edge_bit;
    logic              left_q, above_left_q;
    logic              u_q, out_valid_q;
    logic [1:0]        class_q;

    assign accept = enb & in_valid;

    always_comb begin
        cur_low  = in_sof ? thr_low  : low_q;
        cur_high = in_sof ? thr_high : high_q;
        // Inverted thresholds collapse the weak band to nothing.
        eff_low  = (cur_low > cur_high) ? cur_high : cur_low;
        if (In1 >= cur_high)     pix_class = CLS_STRONG;
        else if (In1 >= eff_low) pix_class = CLS_WEAK;
        else                     pix_class = CLS_NONE;
    end

    always_comb begin
        pix_col     = in_sof ? '0 : col_q;
        pix_first   = in_sof | first_row_q;
        col_d       = col_q;
        first_row_d = first_row_q;
        line_err_d  = line_err_q;
        if (accept) begin
            if (in_sof) line_err_d = 1'b0;
            if (in_eol) begin
                col_d       = '0;
                first_row_d = 1'b0;
            end else if (pix_col == LAST_COL) begin
                col_d       = '0;
                first_row_d = 1'b0;
                line_err_d  = 1'b1;
            end else begin
                col_d       = pix_col + COL_W'(1);
                first_row_d = pix_first;
            end
        end
    end

    always_comb begin
        above      = ~s1_first_q & above_raw;
        left       = (s1_col_q != '0) & left_q;
        above_left = (s1_col_q != '0) & ~s1_first_q & above_left_q;
        edge_bit   = 1'b0;
        case (s1_class_q)
            CLS_STRONG: edge_bit = 1'b1;
            CLS_WEAK:   edge_bit = left | above | above_left;
            default:    edge_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            first_row_q  <= 1'b1;
            line_err_q   <= 1'b0;
            low_q        <= '0;
            high_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_class_q   <= CLS_NONE;
            s1_col_q     <= '0;
            s1_first_q   <= 1'b1;
            left_q       <= 1'b0;
            above_left_q <= 1'b0;
            u_q          <= 1'b0;
            class_q      <= CLS_NONE;
            out_valid_q  <= 1'b0;
        end else if (enb) begin
            col_q       <= col_d;
            first_row_q <= first_row_d;
            line_err_q  <= line_err_d;
            if (in_valid && in_sof) begin
                low_q  <= thr_low;
                high_q <= thr_high;
            end
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_class_q <= pix_class;
                s1_col_q   <= pix_col;
                s1_first_q <= pix_first;
            end
            out_valid_q <= s1_valid_q;
            u_q         <= s1_valid_q & edge_bit;
            class_q     <= s1_valid_q ? s1_class_q : CLS_NONE;
            // Neighbour history only advances on real pixels so bubbles are transparent.
            if (s1_valid_q) begin
                left_q       <= edge_bit;
                above_left_q <= above;
            end
        end
    end

    hyst_line_buffer #(
        .Depth(IMG_W),
        .AddrW(COL_W)
    ) u_line_buffer (
        .clk_i  (clk),
        .we_i   (enb & s1_valid_q),
        .waddr_i(s1_col_q),
        .wdata_i(edge_bit),
        .re_i   (accept),
        .raddr_i(pix_col),
        .rdata_o(above_raw)
    );

    assign u         = u_q;
    assign out_class = class_q;
    assign out_valid = out_valid_q;
    assign line_err  = line_err_q;

`ifdef HYST_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, edge_count_q, edge_count_d;

    always_comb begin
        cnt_inc = cnt_q;
        if (enb && s1_valid_q && edge_bit && (cnt_q != '1)) cnt_inc = cnt_q + CNT_W'(1);
        cnt_d        = cnt_inc;
        edge_count_d = edge_count_q;
        if (accept && in_sof) begin
            edge_count_d = cnt_inc;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            edge_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign edge_count = edge_count_q;
`else
    assign edge_count = '0;
`endif

endmodule
